// File: rtl/marian_rst_pkg.sv
// rtl/marian_rst_pkg.sv - shared types and default timing constants for the Marian reset sequencer
package marian_rst_pkg;

  localparam int unsigned DEF_LOCK_FILTER_CYCLES = 16;
  localparam int unsigned DEF_HOLD_CYCLES        = 32;
  localparam int unsigned DEF_STAGGER_CYCLES     = 8;
  localparam int unsigned DEF_QUIESCE_TIMEOUT    = 1024;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_HOLD,
    ST_REL_XBAR,
    ST_REL_INFRA,
    ST_REL_CORE,
    ST_RUN,
    ST_QUIESCE
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR     = 2'd0,
    CAUSE_NDM     = 2'd1,
    CAUSE_SW      = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_e;

  // Counters only ever hold (parameter - 1), so $clog2 of the largest parameter is enough.
  function automatic int unsigned ctr_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/marian_rst_ctr.sv
// rtl/marian_rst_ctr.sv - loadable saturating down-counter with clear and done flag
module marian_rst_ctr #(
  parameter int unsigned    W         = 4,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= RESET_VAL;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/marian_rst_seq.sv
// rtl/marian_rst_seq.sv - lock filter, ordered reset release, quiesce-before-reset for ndmreset/software requests
module marian_rst_seq
  import marian_rst_pkg::*;
#(
  parameter int unsigned LockFilterCycles = DEF_LOCK_FILTER_CYCLES,
  parameter int unsigned HoldCycles       = DEF_HOLD_CYCLES,
  parameter int unsigned StaggerCycles    = DEF_STAGGER_CYCLES,
  parameter int unsigned QuiesceTimeout   = DEF_QUIESCE_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       locked_i,
  input  logic       ndmreset_i,
  input  logic       sw_rst_req_i,
  input  logic       xbar_idle_i,
  output logic       xbar_rst_no,
  output logic       mem_rst_no,
  output logic       periph_rst_no,
  output logic       core_rst_no,
  output logic       dbg_rst_no,
  output logic       quiesce_o,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned CW = ctr_width(LockFilterCycles, HoldCycles, StaggerCycles, QuiesceTimeout);
  localparam logic [CW-1:0] FILT_LOAD = CW'(LockFilterCycles - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HoldCycles - 1);
  localparam logic [CW-1:0] STAG_LOAD = CW'(StaggerCycles - 1);
  localparam logic [CW-1:0] TMO_LOAD  = CW'(QuiesceTimeout - 1);

  state_e      r_state;
  cause_e      r_cause;
  logic        r_ndm_q;
  logic        r_xbar_rst_n;
  logic        r_mem_rst_n;
  logic        r_periph_rst_n;
  logic        r_core_rst_n;
  logic        r_dbg_rst_n;
  logic        r_quiesce;
  logic        r_rst_done;

  logic          w_filt_done;
  logic          w_ph_done;
  logic          w_tmo_done;
  logic          w_lock_lost;
  logic          w_filt_ok;
  logic          w_hold_exit;
  logic          w_xbar_exit;
  logic          w_ndm_rise;
  logic          w_run_req;
  logic          w_q_exit;
  logic [CW-1:0] w_ph_load_val;

  // Lock loss overrides every other transition, including the ones feeding the counters.
  assign w_lock_lost = !locked_i && (r_state != ST_WAIT_LOCK);
  assign w_filt_ok   = (r_state == ST_WAIT_LOCK) && locked_i && w_filt_done;
  assign w_hold_exit = (r_state == ST_HOLD) && w_ph_done && !ndmreset_i;
  assign w_xbar_exit = (r_state == ST_REL_XBAR) && w_ph_done;
  assign w_ndm_rise  = ndmreset_i && !r_ndm_q;
  assign w_run_req   = (r_state == ST_RUN) && (w_ndm_rise || sw_rst_req_i);
  assign w_q_exit    = (r_state == ST_QUIESCE) && (xbar_idle_i || w_tmo_done);

  assign w_ph_load_val = (w_hold_exit || w_xbar_exit) ? STAG_LOAD : HOLD_LOAD;

  marian_rst_ctr #(.W(CW), .RESET_VAL(FILT_LOAD)) u_filt_ctr (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_clr      (1'b0),
    .i_load     (!locked_i || (r_state != ST_WAIT_LOCK)),
    .i_load_val (FILT_LOAD),
    .i_en       (locked_i && (r_state == ST_WAIT_LOCK)),
    .o_done     (w_filt_done)
  );

  // Shared by HOLD and both stagger phases; saturating at zero is what freezes HOLD under ndmreset.
  marian_rst_ctr #(.W(CW), .RESET_VAL(HOLD_LOAD)) u_phase_ctr (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_clr      (w_lock_lost),
    .i_load     (w_filt_ok || w_q_exit || w_hold_exit || w_xbar_exit),
    .i_load_val (w_ph_load_val),
    .i_en       (r_state inside {ST_HOLD, ST_REL_XBAR, ST_REL_INFRA}),
    .o_done     (w_ph_done)
  );

  marian_rst_ctr #(.W(CW), .RESET_VAL(TMO_LOAD)) u_tmo_ctr (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_clr      (w_lock_lost),
    .i_load     (w_run_req),
    .i_load_val (TMO_LOAD),
    .i_en       (r_state == ST_QUIESCE),
    .o_done     (w_tmo_done)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ndm_q <= 1'b0;
    end else begin
      r_ndm_q <= ndmreset_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || w_lock_lost) begin
      r_state        <= ST_WAIT_LOCK;
      r_cause        <= CAUSE_POR;
      r_xbar_rst_n   <= 1'b0;
      r_mem_rst_n    <= 1'b0;
      r_periph_rst_n <= 1'b0;
      r_core_rst_n   <= 1'b0;
      r_dbg_rst_n    <= 1'b0;
      r_quiesce      <= 1'b0;
      r_rst_done     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_WAIT_LOCK: begin
          if (w_filt_ok) begin
            r_state     <= ST_HOLD;
            r_dbg_rst_n <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_hold_exit) begin
            r_state      <= ST_REL_XBAR;
            r_xbar_rst_n <= 1'b1;
          end
        end
        ST_REL_XBAR: begin
          if (w_ph_done) begin
            r_state        <= ST_REL_INFRA;
            r_mem_rst_n    <= 1'b1;
            r_periph_rst_n <= 1'b1;
          end
        end
        ST_REL_INFRA: begin
          if (w_ph_done) begin
            r_state      <= ST_REL_CORE;
            r_core_rst_n <= 1'b1;
          end
        end
        ST_REL_CORE: begin
          r_state    <= ST_RUN;
          r_rst_done <= 1'b1;
        end
        ST_RUN: begin
          if (w_run_req) begin
            r_state      <= ST_QUIESCE;
            r_quiesce    <= 1'b1;
            r_rst_done   <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_cause      <= w_ndm_rise ? CAUSE_NDM : CAUSE_SW;
          end
        end
        ST_QUIESCE: begin
          if (w_q_exit) begin
            r_state        <= ST_HOLD;
            r_quiesce      <= 1'b0;
            r_xbar_rst_n   <= 1'b0;
            r_mem_rst_n    <= 1'b0;
            r_periph_rst_n <= 1'b0;
            if (!xbar_idle_i) begin
              r_cause <= CAUSE_TIMEOUT;
            end
          end
        end
        default: begin
          r_state <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

  assign xbar_rst_no   = r_xbar_rst_n;
  assign mem_rst_no    = r_mem_rst_n;
  assign periph_rst_no = r_periph_rst_n;
  assign core_rst_no   = r_core_rst_n;
  assign dbg_rst_no    = r_dbg_rst_n;
  assign quiesce_o     = r_quiesce;
  assign rst_done_o    = r_rst_done;
  assign rst_cause_o   = r_cause;

endmodule

// File: tb/tb_marian_rst_seq.sv
// tb/tb_marian_rst_seq.sv - randomized scoreboard bench for the Marian reset sequencer
module tb_marian_rst_seq;

  localparam int unsigned FILT = 16;
  localparam int unsigned HOLD = 32;
  localparam int unsigned STAG = 8;
  localparam int unsigned TMO  = 1024;

  logic       clk_i = 1'b0;
  logic       rst_ni, locked_i, ndmreset_i, sw_rst_req_i, xbar_idle_i;
  logic       xbar_rst_no, mem_rst_no, periph_rst_no, core_rst_no, dbg_rst_no;
  logic       quiesce_o, rst_done_o;
  logic [1:0] rst_cause_o;

  marian_rst_seq dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .locked_i      (locked_i),
    .ndmreset_i    (ndmreset_i),
    .sw_rst_req_i  (sw_rst_req_i),
    .xbar_idle_i   (xbar_idle_i),
    .xbar_rst_no   (xbar_rst_no),
    .mem_rst_no    (mem_rst_no),
    .periph_rst_no (periph_rst_no),
    .core_rst_no   (core_rst_no),
    .dbg_rst_no    (dbg_rst_no),
    .quiesce_o     (quiesce_o),
    .rst_done_o    (rst_done_o),
    .rst_cause_o   (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int unsigned at_cyc;
    logic [8:0]  vec;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [8:0] mon_prev = '0;

  // Reference model: the value each output should settle to after a given edge.
  logic       m_x = 0, m_m = 0, m_p = 0, m_c = 0, m_d = 0, m_q = 0, m_done = 0;
  logic [1:0] m_cause = 0;
  logic [8:0] m_last = '0;

  function automatic logic [8:0] dut_vec();
    return {xbar_rst_no, mem_rst_no, periph_rst_no, core_rst_no, dbg_rst_no,
            quiesce_o, rst_done_o, rst_cause_o};
  endfunction

  task automatic push(input int unsigned e);
    logic [8:0] v;
    v = {m_x, m_m, m_p, m_c, m_d, m_q, m_done, m_cause};
    if (v != m_last) begin
      exp_q.push_back('{at_cyc: e, vec: v});
      m_last = v;
    end
  endtask

  task automatic m_lock_loss(input int unsigned e);
    {m_x, m_m, m_p, m_c, m_d, m_q, m_done} = '0;
    m_cause = 2'd0;
    push(e);
  endtask

  task automatic m_lock_ok(input int unsigned e);
    m_d = 1'b1;
    push(e);
  endtask

  task automatic m_release(input int unsigned x);
    m_x = 1'b1;               push(x);
    m_m = 1'b1; m_p = 1'b1;   push(x + STAG);
    m_c = 1'b1;               push(x + 2 * STAG);
    m_done = 1'b1;            push(x + 2 * STAG + 1);
  endtask

  task automatic m_quiesce(input int unsigned e, input logic [1:0] cause);
    m_c = 1'b0; m_q = 1'b1; m_done = 1'b0; m_cause = cause;
    push(e);
  endtask

  task automatic m_hold_again(input int unsigned e, input bit timed_out);
    m_x = 1'b0; m_m = 1'b0; m_p = 1'b0; m_q = 1'b0;
    if (timed_out) m_cause = 2'd3;
    push(e);
  endtask

  task automatic wait_edge(input int unsigned e);
    while (cyc < e) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  always @(negedge clk_i) begin
    logic [8:0] v;
    exp_t       ex;
    if (mon_en) begin
      v = dut_vec();
      if (v !== mon_prev) begin
        mon_prev = v;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cycle %0d got %b expected no change", cyc, v);
        end else begin
          ex = exp_q.pop_front();
          if (ex.vec !== v || ex.at_cyc != cyc) begin
            errors++;
            $display("FAIL output_step cycle %0d got %b expected %b at cycle %0d",
                     cyc, v, ex.vec, ex.at_cyc);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d expected bench to finish", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned c, q, h, x, r, d, g, lo, n, k;
    rst_ni = 0; locked_i = 1; ndmreset_i = 0; sw_rst_req_i = 0; xbar_idle_i = 0;
    repeat (5) begin
      @(posedge clk_i);
      #1;
    end
    checks++;
    if (dut_vec() !== 9'b0) begin
      errors++;
      $display("FAIL reset_state got %b expected %b", dut_vec(), 9'b0);
    end
    mon_en = 1'b1;

    // Power-on with lock already stable.
    c = cyc; rst_ni = 1;
    h = c + FILT;
    m_lock_ok(h);
    m_release(h + HOLD);
    wait_edge(h + HOLD + 2 * STAG + 4);

    for (int it = 0; it < 2; it++) begin
      // Lock loss from RUN, then a one-cycle lock glitch during filtering.
      lo = $urandom_range(1, 4);
      g  = (it == 0) ? 10 : $urandom_range(1, 14);
      c = cyc; locked_i = 0;
      m_lock_loss(c + 1);
      wait_edge(c + lo); locked_i = 1;
      r = c + lo + 1;
      wait_edge(r + g - 1); locked_i = 0;
      wait_edge(r + g); locked_i = 1;
      h = r + g + FILT;
      m_lock_ok(h);
      m_release(h + HOLD);
      wait_edge(h + HOLD + 2 * STAG + 4);

      // ndmreset pulse, xbar goes idle after d cycles; a software pulse in HOLD is ignored.
      d = (it == 0) ? 5 : $urandom_range(1, 12);
      c = cyc; ndmreset_i = 1;
      q = c + 1;
      m_quiesce(q, 2'd1);
      wait_edge(q); ndmreset_i = 0;
      wait_edge(q + d - 1); xbar_idle_i = 1;
      h = q + d;
      m_hold_again(h, 1'b0);
      wait_edge(h); xbar_idle_i = 0;
      wait_edge(h + 3); sw_rst_req_i = 1;
      wait_edge(h + 4); sw_rst_req_i = 0;
      m_release(h + HOLD);
      wait_edge(h + HOLD + 2 * STAG + 4);

      // Simultaneous ndmreset rise and software request, ndmreset held n cycles.
      n = (it == 0) ? 100 : $urandom_range(5, 60);
      c = cyc; ndmreset_i = 1; sw_rst_req_i = 1;
      q = c + 1;
      m_quiesce(q, 2'd1);
      wait_edge(q); sw_rst_req_i = 0;
      wait_edge(q + 1); xbar_idle_i = 1;
      h = q + 2;
      m_hold_again(h, 1'b0);
      wait_edge(h); xbar_idle_i = 0;
      wait_edge(q + n - 1); ndmreset_i = 0;
      x = (h + HOLD > q + n) ? h + HOLD : q + n;
      m_release(x);
      wait_edge(x + 2 * STAG + 4);
    end

    // Software request with xbar never idle: forced reset after the timeout.
    c = cyc; sw_rst_req_i = 1;
    q = c + 1;
    m_quiesce(q, 2'd2);
    wait_edge(q); sw_rst_req_i = 0;
    h = q + TMO;
    m_hold_again(h, 1'b1);
    m_release(h + HOLD);
    wait_edge(h + HOLD + 2 * STAG + 4);

    // Lock loss while memory/peripherals are released but the core is not.
    c = cyc; sw_rst_req_i = 1;
    q = c + 1;
    m_quiesce(q, 2'd2);
    wait_edge(q); sw_rst_req_i = 0; xbar_idle_i = 1;
    h = q + 1;
    m_hold_again(h, 1'b0);
    wait_edge(h); xbar_idle_i = 0;
    x = h + HOLD;
    m_x = 1'b1;             push(x);
    m_m = 1'b1; m_p = 1'b1; push(x + STAG);
    k = $urandom_range(1, 7);
    wait_edge(x + STAG + k - 1); locked_i = 0;
    m_lock_loss(x + STAG + k);
    wait_edge(x + STAG + k); locked_i = 1;
    h = x + STAG + k + FILT;
    m_lock_ok(h);
    m_release(h + HOLD);
    wait_edge(h + HOLD + 2 * STAG + 10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d outstanding expected 0 (next at cycle %0d)",
               exp_q.size(), exp_q[0].at_cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
